// File: rtl/led_pkg.sv
// Shared LED timing constants and helpers; imported by the PWM and fade stages
// so that their duty widths always agree.
package led_pkg;

    localparam int unsigned DEFAULT_PWM_INTERVAL = 600;

    localparam bit LED_ACTIVE_LOW  = 1'b1;
    localparam bit LED_ACTIVE_HIGH = 1'b0;

    function automatic int unsigned duty_w(input int unsigned interval);
        return $clog2(interval + 1);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period-boundary shadow duty, phase-offset wrap, compare and
// registered, polarity-adjusted output.
module pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned OFFSET       = 0,
    parameter int unsigned PWM_INTERVAL = DEFAULT_PWM_INTERVAL,
    parameter bit          ACTIVE_LOW   = LED_ACTIVE_LOW,
    parameter int unsigned DW           = duty_w(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [DW-1:0] cnt,
    input  logic [DW-1:0] duty_in,
    output logic          pwm_out
);

    localparam logic [DW:0] OFF = (DW+1)'(OFFSET);
    localparam logic [DW:0] PER = (DW+1)'(PWM_INTERVAL);

    logic [DW-1:0] shadow;
    logic [DW:0]   sum;
    logic [DW:0]   ph;
    logic          on;

    // One extra bit keeps cnt+OFFSET exact before the single wrap subtraction.
    always_comb begin
        sum = {1'b0, cnt} + OFF;
        ph  = sum;
        if (sum >= PER) begin
            ph = sum - PER;
        end
    end

    // Duty >= PWM_INTERVAL always exceeds the largest phase, so no gap at wrap.
    assign on = en & (ph < {1'b0, shadow});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            pwm_out <= ACTIVE_LOW;
        end else begin
            if (load) begin
                shadow <= duty_in;
            end
            pwm_out <= on ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/pwm_rgb.sv
// Multi-channel PWM generator: shared period counter and strobe, with one
// staggered-phase pwm_channel per LED.
module pwm_rgb
    import led_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = DEFAULT_PWM_INTERVAL,
    parameter int unsigned NUM_CH       = 3,
    parameter bit          ACTIVE_LOW   = LED_ACTIVE_LOW,
    parameter int unsigned DW           = duty_w(PWM_INTERVAL)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_CH-1:0][DW-1:0]  duty_in,
    output logic [NUM_CH-1:0]          pwm_out,
    output logic                       period_strobe
);

    localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);

    logic [DW-1:0] cnt;
    logic          last;
    logic          load;

    assign last = (cnt == CNT_LAST);
    // While disabled the shadows track duty_in so re-enable uses it at once.
    assign load = last | ~en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            period_strobe <= 1'b0;
        end else begin
            period_strobe <= en & last;
            if (!en || last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_channel #(
            .OFFSET       (k * (PWM_INTERVAL / NUM_CH)),
            .PWM_INTERVAL (PWM_INTERVAL),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DW           (DW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .load    (load),
            .cnt     (cnt),
            .duty_in (duty_in[k]),
            .pwm_out (pwm_out[k])
        );
    end

endmodule
